// File: rtl/ped_countdown_display.sv
// Pedestrian WALK/CLEAR countdown timer driving a multiplexed 7-segment display.
// Optional macro PED_LZ_BLANK_EN blanks leading zero digits above the units digit.
module ped_countdown_display #(
   parameter int FCLK_HZ        = 100_000_000,
   parameter int NUM_DIGITS     = 2,
   parameter int CLEAR_SECS     = 5,
   parameter int MUX_HZ         = 1000,
   parameter int FLASH_HZ       = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  walk_start,
   input  logic                  abort,
   input  logic [13:0]           walk_secs,
   output logic                  busy,
   output logic                  walk_led,
   output logic                  dont_walk_led,
   output logic                  walk_done,
   output logic                  aborted,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int MAX_REM    = (NUM_DIGITS == 1) ? 9 : (NUM_DIGITS == 2) ? 99 :
                               (NUM_DIGITS == 3) ? 999 : 9999;
   localparam int CLEAR_INIT = (CLEAR_SECS > MAX_REM) ? MAX_REM : CLEAR_SECS;
   localparam int MUX_RAW    = FCLK_HZ / MUX_HZ;
   localparam int MUX_DIV    = (MUX_RAW < 1) ? 1 : MUX_RAW;
   localparam int FLASH_RAW  = FCLK_HZ / (2 * FLASH_HZ);
   localparam int FLASH_DIV  = (FLASH_RAW < 1) ? 1 : FLASH_RAW;
   localparam int SEC_W      = (FCLK_HZ > 1) ? $clog2(FCLK_HZ) : 1;
   localparam int MUX_W      = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
   localparam int FLASH_W    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BCD_W      = 4 * NUM_DIGITS;
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF =
      (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   typedef enum logic [1:0] {IDLE, WALK, CLEAR} state_t;

   state_t               state, state_next;
   logic [13:0]          rem, rem_next;
   logic [SEC_W-1:0]     sec_cnt;
   logic [MUX_W-1:0]     mux_cnt;
   logic [FLASH_W-1:0]   flash_cnt;
   logic [IDX_W-1:0]     digit_idx;
   logic                 flash_q;
   logic                 sec_tick, start_acc, clear_entry, done_next, abort_next;
   logic [BCD_W-1:0]     bcd;
   logic [3:0]           cur_digit;
   logic                 blank_cur;
   logic [6:0]           seg_pat;
   logic [NUM_DIGITS-1:0] an_onehot;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_encode = 7'h7E;
         4'd1:    seg_encode = 7'h30;
         4'd2:    seg_encode = 7'h6D;
         4'd3:    seg_encode = 7'h79;
         4'd4:    seg_encode = 7'h33;
         4'd5:    seg_encode = 7'h5B;
         4'd6:    seg_encode = 7'h5F;
         4'd7:    seg_encode = 7'h70;
         4'd8:    seg_encode = 7'h7F;
         4'd9:    seg_encode = 7'h7B;
         default: seg_encode = 7'h00;
      endcase
   endfunction

   assign sec_tick      = (state != IDLE) && (sec_cnt == SEC_W'(FCLK_HZ - 1));
   assign busy          = (state != IDLE);
   assign walk_led      = (state == WALK);
   assign dont_walk_led = (state == CLEAR) ? flash_q : (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Abort outranks both a new start and a coincident seconds tick.
   always_comb begin
      state_next  = state;
      rem_next    = rem;
      start_acc   = 1'b0;
      clear_entry = 1'b0;
      done_next   = 1'b0;
      abort_next  = 1'b0;
      case (state)
         IDLE: begin
            if (walk_start && !abort) begin
               state_next = WALK;
               rem_next   = (walk_secs > 14'(MAX_REM)) ? 14'(MAX_REM) : walk_secs;
               start_acc  = 1'b1;
            end
         end
         WALK: begin
            if (abort) begin
               state_next = IDLE;
               rem_next   = '0;
               abort_next = 1'b1;
            end else if (sec_tick) begin
               if (rem != '0) begin
                  rem_next = rem - 14'd1;
               end else begin
                  state_next  = CLEAR;
                  rem_next    = 14'(CLEAR_INIT);
                  clear_entry = 1'b1;
               end
            end
         end
         CLEAR: begin
            if (abort) begin
               state_next = IDLE;
               rem_next   = '0;
               abort_next = 1'b1;
            end else if (sec_tick) begin
               if (rem != '0) begin
                  rem_next = rem - 14'd1;
               end else begin
                  state_next = IDLE;
                  rem_next   = '0;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem       <= '0;
         sec_cnt   <= '0;
         mux_cnt   <= '0;
         flash_cnt <= '0;
         digit_idx <= '0;
         flash_q   <= 1'b1;
         walk_done <= 1'b0;
         aborted   <= 1'b0;
         seg       <= SEG_OFF;
         an        <= AN_OFF;
      end else begin
         rem       <= rem_next;
         walk_done <= done_next;
         aborted   <= abort_next;
         if (state == IDLE || start_acc || sec_tick) sec_cnt <= '0;
         else                                        sec_cnt <= sec_cnt + SEC_W'(1);
         if (clear_entry) begin
            flash_cnt <= '0;
            flash_q   <= 1'b1;
         end else if (state == CLEAR) begin
            if (flash_cnt == FLASH_W'(FLASH_DIV - 1)) begin
               flash_cnt <= '0;
               flash_q   <= ~flash_q;
            end else begin
               flash_cnt <= flash_cnt + FLASH_W'(1);
            end
         end
         if (mux_cnt == MUX_W'(MUX_DIV - 1)) begin
            mux_cnt <= '0;
            if (digit_idx == IDX_W'(NUM_DIGITS - 1)) digit_idx <= '0;
            else                                     digit_idx <= digit_idx + IDX_W'(1);
         end else begin
            mux_cnt <= mux_cnt + MUX_W'(1);
         end
         if (state == IDLE) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
         end else begin
            seg <= blank_cur ? SEG_OFF : ((SEG_ACTIVE_LOW != 0) ? ~seg_pat : seg_pat);
            an  <= (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
         end
      end
   end

   // Shift-and-add-3 binary to BCD; rem never exceeds the digit capacity.
   always_comb begin
      bcd = '0;
      for (int i = 13; i >= 0; i--) begin
         for (int d = 0; d < NUM_DIGITS; d++)
            if (bcd[4*d +: 4] > 4'd4) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         bcd = {bcd[BCD_W-2:0], rem[i]};
      end
   end

   always_comb begin
      cur_digit = 4'd0;
      for (int d = 0; d < NUM_DIGITS; d++)
         if (digit_idx == IDX_W'(d)) cur_digit = bcd[4*d +: 4];
   end

   assign seg_pat   = seg_encode(cur_digit);
   assign an_onehot = NUM_DIGITS'(1) << digit_idx;

`ifdef PED_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] lead_zero;
   logic                  zero_run;

   always_comb begin
      lead_zero = '0;
      zero_run  = 1'b1;
      for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
         zero_run     = zero_run && (bcd[4*d +: 4] == 4'd0);
         lead_zero[d] = zero_run;
      end
   end

   always_comb begin
      blank_cur = 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++)
         if (digit_idx == IDX_W'(d)) blank_cur = lead_zero[d];
   end
`else
   assign blank_cur = 1'b0;
`endif

endmodule

// File: tb/tb_ped_countdown_display.sv
// Directed bench for ped_countdown_display with a 20-cycle second and 2 active-low digits.
module tb_ped_countdown_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        walk_start = 1'b0;
   logic        abort = 1'b0;
   logic [13:0] walk_secs = '0;
   logic        busy, walk_led, dont_walk_led, walk_done, aborted;
   logic [6:0]  seg;
   logic [1:0]  an;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] S_OFF = 7'h7F;
   localparam logic [6:0] S0 = 7'h01;
   localparam logic [6:0] S1 = 7'h4F;
   localparam logic [6:0] S2 = 7'h12;
   localparam logic [6:0] S5 = 7'h24;
   localparam logic [6:0] S7 = 7'h0F;
   localparam logic [6:0] S8 = 7'h00;
   localparam logic [6:0] S9 = 7'h04;
`ifdef PED_LZ_BLANK_EN
   localparam logic [6:0] TENS_ZERO = S_OFF;
`else
   localparam logic [6:0] TENS_ZERO = S0;
`endif

   always #5 clk = ~clk;

   ped_countdown_display #(
      .FCLK_HZ(20), .NUM_DIGITS(2), .CLEAR_SECS(2), .MUX_HZ(10), .FLASH_HZ(5),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .walk_start(walk_start), .abort(abort),
      .walk_secs(walk_secs), .busy(busy), .walk_led(walk_led),
      .dont_walk_led(dont_walk_led), .walk_done(walk_done), .aborted(aborted),
      .seg(seg), .an(an)
   );

   // Pulses walk_start for one cycle; returns at the first WALK cycle.
   task automatic start_walk(input logic [13:0] secs);
      walk_secs  = secs;
      walk_start = 1'b1;
      @(negedge clk);
      walk_start = 1'b0;
   endtask

   task automatic abort_pulse();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
   endtask

   // Samples n cycles and checks each seg against the digit selected by an.
   task automatic check_display(input string name, input int n,
                                input logic [6:0] tens_exp, input logic [6:0] units_exp);
      for (int k = 0; k < n; k++) begin
         total++;
         if (an !== 2'b10 && an !== 2'b01) begin
            bad++;
            $display("[TB] FAIL %s_an got=%b exp=10 or 01", name, an);
         end else if (seg !== ((an == 2'b10) ? units_exp : tens_exp)) begin
            bad++;
            $display("[TB] FAIL %s_seg an=%b got=%h exp=%h", name, an, seg,
                     (an == 2'b10) ? units_exp : tens_exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
      total++; if (walk_led !== 1'b0) begin bad++; $display("[TB] FAIL rst_walk got=%b exp=0", walk_led); end
      total++; if (dont_walk_led !== 1'b1) begin bad++; $display("[TB] FAIL rst_dontwalk got=%b exp=1", dont_walk_led); end
      total++; if (walk_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%b exp=0", walk_done); end
      total++; if (aborted !== 1'b0) begin bad++; $display("[TB] FAIL rst_aborted got=%b exp=0", aborted); end
      total++; if (an !== 2'b11) begin bad++; $display("[TB] FAIL rst_an got=%b exp=11", an); end
      total++; if (seg !== S_OFF) begin bad++; $display("[TB] FAIL rst_seg got=%h exp=%h", seg, S_OFF); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_walk_sequence();
      int walk_cnt = 0;
      int flash_err = 0;
      int busy_err = 0;
      start_walk(14'd3);
      total++; if (dont_walk_led !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("[TB] FAIL seq_walk_entry dontwalk=%b busy=%b exp=0,1", dont_walk_led, busy);
      end
      while (walk_led && walk_cnt < 200) begin
         walk_cnt++;
         @(negedge clk);
      end
      total++; if (walk_cnt != 80) begin bad++; $display("[TB] FAIL seq_walk_len got=%0d exp=80", walk_cnt); end
      for (int i = 0; i < 60; i++) begin
         if (dont_walk_led !== (((i / 2) % 2) == 0)) flash_err++;
         if (busy !== 1'b1 || walk_done !== 1'b0 || walk_led !== 1'b0) busy_err++;
         @(negedge clk);
      end
      total++; if (flash_err != 0) begin bad++; $display("[TB] FAIL seq_flash errors got=%0d exp=0", flash_err); end
      total++; if (busy_err != 0) begin bad++; $display("[TB] FAIL seq_clear_flags errors got=%0d exp=0", busy_err); end
      total++; if (walk_done !== 1'b1) begin bad++; $display("[TB] FAIL seq_done got=%b exp=1", walk_done); end
      total++; if (busy !== 1'b0 || dont_walk_led !== 1'b1) begin
         bad++; $display("[TB] FAIL seq_idle busy=%b dontwalk=%b exp=0,1", busy, dont_walk_led);
      end
      @(negedge clk);
      total++; if (walk_done !== 1'b0) begin bad++; $display("[TB] FAIL seq_done_width got=%b exp=0", walk_done); end
   endtask

   task automatic test_digits();
      logic [1:0] an_hist [8];
      logic [6:0] seg_hist [8];
      start_walk(14'd12);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         an_hist[k]  = an;
         seg_hist[k] = seg;
         @(negedge clk);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (an_hist[k] !== 2'b10 && an_hist[k] !== 2'b01) begin
            bad++; $display("[TB] FAIL dig_an got=%b exp=10 or 01", an_hist[k]);
         end else if (seg_hist[k] !== ((an_hist[k] == 2'b10) ? S2 : S1)) begin
            bad++; $display("[TB] FAIL dig_seg an=%b got=%h exp=%h", an_hist[k], seg_hist[k],
                            (an_hist[k] == 2'b10) ? S2 : S1);
         end
      end
      for (int k = 0; k < 6; k++) begin
         total++;
         if (an_hist[k+2] !== ~an_hist[k]) begin
            bad++; $display("[TB] FAIL dig_an_period k=%0d got=%b exp=%b", k, an_hist[k+2], ~an_hist[k]);
         end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++; if (aborted !== 1'b1 || walk_done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL dig_abort aborted=%b done=%b busy=%b exp=1,0,0", aborted, walk_done, busy);
      end
      @(negedge clk);
      total++; if (aborted !== 1'b0) begin bad++; $display("[TB] FAIL dig_abort_width got=%b exp=0", aborted); end
   endtask

   task automatic test_clamp();
      start_walk(14'd150);
      repeat (2) @(negedge clk);
      check_display("clamp99", 4, S9, S9);
      repeat (16) @(negedge clk);
      check_display("clamp98", 4, S9, S8);
      abort_pulse();
   endtask

   task automatic test_blank();
      start_walk(14'd7);
      repeat (2) @(negedge clk);
      check_display("blank7", 6, TENS_ZERO, S7);
      abort_pulse();
   endtask

   task automatic test_abort_clear();
      int walk_cnt = 0;
      int done_seen = 0;
      start_walk(14'd0);
      while (walk_led && walk_cnt < 100) begin
         walk_cnt++;
         @(negedge clk);
      end
      total++; if (walk_cnt != 20) begin bad++; $display("[TB] FAIL zero_walk_len got=%0d exp=20", walk_cnt); end
      repeat (25) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++; if (busy !== 1'b0 || walk_led !== 1'b0 || dont_walk_led !== 1'b1) begin
         bad++; $display("[TB] FAIL abclr_idle busy=%b walk=%b dontwalk=%b exp=0,0,1", busy, walk_led, dont_walk_led);
      end
      total++; if (aborted !== 1'b1 || walk_done !== 1'b0) begin
         bad++; $display("[TB] FAIL abclr_pulse aborted=%b done=%b exp=1,0", aborted, walk_done);
      end
      @(negedge clk);
      total++; if (an !== 2'b11 || seg !== S_OFF || aborted !== 1'b0) begin
         bad++; $display("[TB] FAIL abclr_display an=%b seg=%h aborted=%b exp=11,%h,0", an, seg, aborted, S_OFF);
      end
      for (int i = 0; i < 40; i++) begin
         if (walk_done !== 1'b0 || busy !== 1'b0) done_seen++;
         @(negedge clk);
      end
      total++; if (done_seen != 0) begin bad++; $display("[TB] FAIL abclr_no_done got=%0d exp=0", done_seen); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++; if (aborted !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL idle_abort aborted=%b busy=%b exp=0,0", aborted, busy);
      end
   endtask

   task automatic test_reset_mid_walk();
      int stray = 0;
      start_walk(14'd5);
      repeat (8) @(negedge clk);
      start_walk(14'd9);
      repeat (3) @(negedge clk);
      total++; if (walk_led !== 1'b1) begin bad++; $display("[TB] FAIL busy_start_walk got=%b exp=1", walk_led); end
      check_display("busy_ignore", 4, TENS_ZERO, S5);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++; if (busy !== 1'b0 || walk_led !== 1'b0 || dont_walk_led !== 1'b1) begin
         bad++; $display("[TB] FAIL midrst_state busy=%b walk=%b dontwalk=%b exp=0,0,1", busy, walk_led, dont_walk_led);
      end
      total++; if (walk_done !== 1'b0 || aborted !== 1'b0) begin
         bad++; $display("[TB] FAIL midrst_pulses done=%b aborted=%b exp=0,0", walk_done, aborted);
      end
      total++; if (an !== 2'b11 || seg !== S_OFF) begin
         bad++; $display("[TB] FAIL midrst_display an=%b seg=%h exp=11,%h", an, seg, S_OFF);
      end
      for (int i = 0; i < 150; i++) begin
         if (walk_done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) stray++;
         @(negedge clk);
      end
      total++; if (stray != 0) begin bad++; $display("[TB] FAIL midrst_quiet got=%0d exp=0", stray); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_walk_sequence();
      test_digits();
      test_clamp();
      test_blank();
      test_abort_clear();
      test_reset_mid_walk();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
